// File: rtl/vga_word_sequencer.sv
// vga_word_sequencer: buffers a word of character-ROM addresses and feeds them
// one at a time to the per-character VGA drawing stage. Each character gets an
// address/origin pair plus a single plot pulse. The sequencer then waits on the
// drawing stage's ready level and advances x, wrapping to a new text line when
// the next character would cross the right screen edge.
// Optional build macro: SPACE_SKIP_EN. When it is defined, space characters
// (8'h20) are not plotted, but x still advances past them.
`timescale 1ns/1ps
module vga_word_sequencer #(
    parameter int MAX_CHARS = 16,
    parameter int CHAR_W    = 6,
    parameter int LINE_H    = 8,
    parameter int X_MAX     = 320
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         char_wr,
    input  logic [7:0]                   char_data,
    input  logic                         buf_clear,
    input  logic                         start,
    input  logic [8:0]                   x_origin,
    input  logic [8:0]                   y_origin,
    input  logic                         ready_to_start_character,
    output logic [7:0]                   address,
    output logic [8:0]                   x_input,
    output logic [8:0]                   y_input,
    output logic                         enable_character_plot,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(MAX_CHARS):0]   char_count,
    output logic                         overflow
);

    localparam int IW = $clog2(MAX_CHARS);
    localparam int CW = IW + 1;

`ifdef SPACE_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_NEXT      = 3'd5,
        S_FINISH    = 3'd6
    } state_t;

    // True when a character is buffered but must not be sent to the drawing stage
    function automatic logic is_skipped(input logic [7:0] c);
        return SKIP_EN && (c == 8'h20);
    endfunction

    state_t          r_state;
    logic [7:0]      r_buf [MAX_CHARS];
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic [CW-1:0]   r_idx;
    logic [1:0]      r_ack_cnt;
    logic [8:0]      r_x_org;
    logic [8:0]      r_y_org;
    logic [8:0]      r_x_cur;
    logic [8:0]      r_y_cur;
    logic [7:0]      r_address;
    logic [8:0]      r_x_input;
    logic [8:0]      r_y_input;
    logic            r_enable;
    logic            r_busy;
    logic            r_done;

    logic            w_idle;
    logic [CW-1:0]   w_idx_inc;
    logic            w_last;
    logic [9:0]      w_x_step;
    logic [9:0]      w_x_far;
    logic            w_wrap;
    logic [8:0]      w_x_adv;
    logic [8:0]      w_y_adv;
    logic [7:0]      w_first_char;
    logic [7:0]      w_next_char;

    assign w_idle       = (r_state == S_IDLE);
    assign w_idx_inc    = r_idx + CW'(1);
    assign w_last       = (w_idx_inc == r_count);
    // x arithmetic is done 10 bits wide so the edge test cannot alias past 511
    assign w_x_step     = {1'b0, r_x_cur} + 10'(CHAR_W);
    assign w_x_far      = w_x_step + 10'(CHAR_W);
    assign w_wrap       = (w_x_far > 10'(X_MAX));
    assign w_x_adv      = w_wrap ? r_x_org : w_x_step[8:0];
    assign w_y_adv      = w_wrap ? (r_y_cur + 9'(LINE_H)) : r_y_cur;
    assign w_first_char = r_buf[0];
    assign w_next_char  = r_buf[w_idx_inc[IW-1:0]];

    // Word buffer: appends and clears are only honoured while the sequencer is idle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < MAX_CHARS; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else if (w_idle) begin
            if (buf_clear) begin
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else if (char_wr) begin
                if (r_count == CW'(MAX_CHARS)) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_buf[r_count[IW-1:0]] <= char_data;
                    r_count                <= r_count + CW'(1);
                end
            end
        end
    end

    // Sequencer FSM: walks the buffer and registers every output toward the drawing stage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_ack_cnt <= 2'd0;
            r_x_org   <= 9'd0;
            r_y_org   <= 9'd0;
            r_x_cur   <= 9'd0;
            r_y_cur   <= 9'd0;
            r_address <= 8'h00;
            r_x_input <= 9'd0;
            r_y_input <= 9'd0;
            r_enable  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_enable <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (start) begin
                        r_x_org <= x_origin;
                        r_y_org <= y_origin;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_x_cur <= r_x_org;
                    r_y_cur <= r_y_org;
                    r_idx   <= '0;
                    if (r_count == '0) begin
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else if (is_skipped(w_first_char)) begin
                        r_state <= S_NEXT;
                    end else begin
                        r_address <= w_first_char;
                        r_x_input <= r_x_org;
                        r_y_input <= r_y_org;
                        r_enable  <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_ack_cnt <= 2'd0;
                    r_state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    // A stage that never drops ready is treated as having accepted after 4 cycles
                    if (!ready_to_start_character || (r_ack_cnt == 2'd3)) begin
                        r_state <= S_WAIT_DONE;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 2'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (ready_to_start_character) begin
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    r_idx <= w_idx_inc;
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_x_cur <= w_x_adv;
                        r_y_cur <= w_y_adv;
                        if (is_skipped(w_next_char)) begin
                            r_state <= S_NEXT;
                        end else begin
                            r_address <= w_next_char;
                            r_x_input <= w_x_adv;
                            r_y_input <= w_y_adv;
                            r_enable  <= 1'b1;
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign address               = r_address;
    assign x_input               = r_x_input;
    assign y_input               = r_y_input;
    assign enable_character_plot = r_enable;
    assign busy                  = r_busy;
    assign done                  = r_done;
    assign char_count            = r_count;
    assign overflow              = r_overflow;

endmodule

// File: tb/tb_vga_word_sequencer.sv
// Self-checking bench for vga_word_sequencer: a behavioural drawing-stage model
// answers each plot pulse, and a reference model predicts the plot list.
`timescale 1ns/1ps
module tb_vga_word_sequencer;

    localparam int MAXC = 16;
`ifdef SPACE_SKIP_EN
    localparam bit SKIP         = 1'b1;
    localparam int SPACE_PULSES = 2;
`else
    localparam bit SKIP         = 1'b0;
    localparam int SPACE_PULSES = 3;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       char_wr = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       buf_clear = 1'b0;
    logic       start = 1'b0;
    logic [8:0] x_origin = 9'd0;
    logic [8:0] y_origin = 9'd0;
    logic       ready = 1'b1;
    logic [7:0] address;
    logic [8:0] x_input;
    logic [8:0] y_input;
    logic       enable_character_plot;
    logic       busy;
    logic       done;
    logic [4:0] char_count;
    logic       overflow;

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [25:0] obs_q[$];
    logic [25:0] exp_q[$];
    logic [7:0]  mdl_buf[$];
    bit          mdl_ovf = 1'b0;
    bit          m_hold_high = 1'b0;
    int          m_len_min = 1;
    int          m_len_max = 6;
    int          m_low_left = 0;
    int          done_seen = 0;

    vga_word_sequencer dut (
        .clk                      (clk),
        .resetn                   (resetn),
        .char_wr                  (char_wr),
        .char_data                (char_data),
        .buf_clear                (buf_clear),
        .start                    (start),
        .x_origin                 (x_origin),
        .y_origin                 (y_origin),
        .ready_to_start_character (ready),
        .address                  (address),
        .x_input                  (x_input),
        .y_input                  (y_input),
        .enable_character_plot    (enable_character_plot),
        .busy                     (busy),
        .done                     (done),
        .char_count               (char_count),
        .overflow                 (overflow)
    );

    always #5 clk = ~clk;

    // Drawing-stage model: drops ready after each plot pulse, raises it after a random busy time
    always @(negedge clk) begin
        if (!resetn) begin
            ready = 1'b1;
            m_low_left = 0;
        end else if (m_hold_high) begin
            ready = 1'b1;
        end else if (enable_character_plot) begin
            ready = 1'b0;
            m_low_left = $urandom_range(m_len_max, m_len_min);
        end else if (m_low_left > 0) begin
            m_low_left--;
            if (m_low_left == 0) ready = 1'b1;
        end
    end

    // Pulse collector: records every plot request and done pulse
    always @(negedge clk) begin
        if (resetn && enable_character_plot) obs_q.push_back({address, x_input, y_input});
        if (resetn && done) done_seen++;
    end

    // Reference: plot list derived from the buffered word, origin and text layout rules
    function automatic void model_plots(input int x0, input int y0);
        int x;
        int y;
        logic [8:0] xs;
        logic [8:0] ys;
        exp_q.delete();
        x = x0;
        y = y0;
        for (int i = 0; i < mdl_buf.size(); i++) begin
            xs = x[8:0];
            ys = y[8:0];
            if (!(SKIP && mdl_buf[i] == 8'h20)) exp_q.push_back({mdl_buf[i], xs, ys});
            if (i + 1 < mdl_buf.size()) begin
                x = x + 6;
                if (x + 6 > 320) begin
                    x = x0;
                    y = (y + 8) % 512;
                end
            end
        end
    endfunction

    task automatic wr_char(input logic [7:0] d);
        @(negedge clk);
        char_wr = 1'b1;
        char_data = d;
        @(negedge clk);
        char_wr = 1'b0;
        if (mdl_buf.size() < MAXC) mdl_buf.push_back(d);
        else mdl_ovf = 1'b1;
    endtask

    task automatic clear_buf();
        @(negedge clk);
        buf_clear = 1'b1;
        @(negedge clk);
        buf_clear = 1'b0;
        mdl_buf.delete();
        mdl_ovf = 1'b0;
    endtask

    // Starts the buffered word and waits (bounded) for the done pulse
    task automatic play_word(input logic [8:0] x0, input logic [8:0] y0, output bit timed_out);
        obs_q.delete();
        done_seen = 0;
        timed_out = 1'b1;
        @(negedge clk);
        x_origin = x0;
        y_origin = y0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        cmp_cnt++;
        if ({address, x_input, y_input, enable_character_plot, busy, done, char_count, overflow} !== 35'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {address, x_input, y_input, enable_character_plot, busy, done, char_count, overflow});
        end
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        bit to;
        clear_buf();
        wr_char(8'h41); wr_char(8'h42); wr_char(8'h43);
        cmp_cnt++;
        if (char_count !== 5'd3) begin err_cnt++; $display("FAIL basic_count: got %0d expected 3", char_count); end
        m_hold_high = 1'b0; m_len_min = 5; m_len_max = 5;
        model_plots(10, 20);
        play_word(9'd10, 9'd20, to);
        cmp_cnt++;
        if (to !== 1'b0) begin err_cnt++; $display("FAIL basic_timeout: got timeout expected done"); end
        cmp_cnt++;
        if (obs_q.size() !== exp_q.size()) begin err_cnt++; $display("FAIL basic_npulses: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            cmp_cnt++;
            if (obs_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL basic_plot[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        @(negedge clk);
        cmp_cnt++;
        if ({busy, done} !== 2'b00) begin err_cnt++; $display("FAIL basic_idle: got busy/done %b expected 00", {busy, done}); end
    endtask

    task automatic test_wrap();
        bit to;
        logic [8:0] y0;
        y0 = 9'($urandom_range(0, 511));
        clear_buf();
        for (int i = 0; i < 3; i++) wr_char(8'($urandom_range(8'h30, 8'h5a)));
        m_len_min = 1; m_len_max = 6;
        model_plots(306, int'(y0));
        play_word(9'd306, y0, to);
        cmp_cnt++;
        if (to !== 1'b0) begin err_cnt++; $display("FAIL wrap_timeout: got timeout expected done"); end
        cmp_cnt++;
        if (obs_q.size() !== exp_q.size()) begin err_cnt++; $display("FAIL wrap_npulses: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            cmp_cnt++;
            if (obs_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL wrap_plot[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        clear_buf();
        for (int i = 0; i < 17; i++) wr_char(8'($urandom));
        cmp_cnt++;
        if ({char_count, overflow} !== {5'(mdl_buf.size()), mdl_ovf} || char_count !== 5'd16) begin
            err_cnt++; $display("FAIL overflow_set: got count=%0d ovf=%b expected count=16 ovf=1", char_count, overflow);
        end
        clear_buf();
        cmp_cnt++;
        if ({char_count, overflow} !== 6'd0) begin
            err_cnt++; $display("FAIL overflow_clear: got count=%0d ovf=%b expected count=0 ovf=0", char_count, overflow);
        end
    endtask

    task automatic test_empty();
        clear_buf();
        obs_q.delete();
        @(negedge clk);
        start = 1'b1;
        x_origin = 9'($urandom);
        y_origin = 9'($urandom);
        @(negedge clk);
        start = 1'b0;
        cmp_cnt++;
        if ({busy, done, enable_character_plot} !== 3'b100) begin err_cnt++; $display("FAIL empty_cycle1: got busy/done/en %b expected 100", {busy, done, enable_character_plot}); end
        @(negedge clk);
        cmp_cnt++;
        if ({busy, done, enable_character_plot} !== 3'b110) begin err_cnt++; $display("FAIL empty_cycle2: got busy/done/en %b expected 110", {busy, done, enable_character_plot}); end
        @(negedge clk);
        cmp_cnt++;
        if ({busy, done, obs_q.size() == 0} !== 3'b001) begin err_cnt++; $display("FAIL empty_cycle3: got busy/done/nopulse %b expected 001", {busy, done, obs_q.size() == 0}); end
    endtask

    task automatic test_latency();
        clear_buf();
        wr_char(8'($urandom)); wr_char(8'($urandom));
        m_len_min = 3; m_len_max = 3;
        @(negedge clk);
        start = 1'b1;
        x_origin = 9'd100;
        y_origin = 9'd50;
        @(negedge clk);
        start = 1'b0;
        cmp_cnt++;
        if ({busy, enable_character_plot} !== 2'b10) begin err_cnt++; $display("FAIL latency_cycle1: got busy/en %b expected 10", {busy, enable_character_plot}); end
        @(negedge clk);
        cmp_cnt++;
        if ({enable_character_plot, address, x_input, y_input} !== {1'b1, mdl_buf[0], 9'd100, 9'd50}) begin
            err_cnt++; $display("FAIL latency_cycle2: got en=%b addr=%h x=%0d y=%0d expected en=1 addr=%h x=100 y=50",
                                enable_character_plot, address, x_input, y_input, mdl_buf[0]);
        end
        begin : wait_done
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                if (done) begin seen = 1'b1; break; end
            end
            cmp_cnt++;
            if (seen !== 1'b1) begin err_cnt++; $display("FAIL latency_done: got no done expected done"); end
        end
    endtask

    task automatic test_timeout();
        bit to;
        clear_buf();
        for (int i = 0; i < 4; i++) wr_char(8'($urandom_range(8'h41, 8'h5a)));
        m_hold_high = 1'b1;
        model_plots(40, 70);
        play_word(9'd40, 9'd70, to);
        m_hold_high = 1'b0;
        cmp_cnt++;
        if (to !== 1'b0) begin err_cnt++; $display("FAIL timeout_hang: got timeout expected done"); end
        cmp_cnt++;
        if (obs_q.size() !== exp_q.size()) begin err_cnt++; $display("FAIL timeout_npulses: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            cmp_cnt++;
            if (obs_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL timeout_plot[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_busy_ignore();
        bit to;
        clear_buf();
        for (int i = 0; i < 16; i++) wr_char(8'($urandom_range(8'h41, 8'h5a)));
        m_len_min = 4; m_len_max = 4;
        model_plots(0, 100);
        obs_q.delete();
        done_seen = 0;
        @(negedge clk);
        x_origin = 9'd0; y_origin = 9'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        char_wr = 1'b1; char_data = 8'h55;
        @(negedge clk);
        char_wr = 1'b0; buf_clear = 1'b1;
        @(negedge clk);
        buf_clear = 1'b0; start = 1'b1; x_origin = 9'd200;
        @(negedge clk);
        start = 1'b0;
        to = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) begin to = 1'b0; break; end
        end
        repeat (4) @(negedge clk);
        cmp_cnt++;
        if ({to, char_count, overflow, done_seen == 1} !== {1'b0, 5'd16, 1'b0, 1'b1}) begin
            err_cnt++; $display("FAIL busy_ignore: got to=%b count=%0d ovf=%b dones=%0d expected to=0 count=16 ovf=0 dones=1",
                                to, char_count, overflow, done_seen);
        end
        cmp_cnt++;
        if (obs_q.size() !== exp_q.size()) begin err_cnt++; $display("FAIL busy_npulses: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            cmp_cnt++;
            if (obs_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL busy_plot[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        // Buffer retained: replay the same word from a new origin
        model_plots(150, 3);
        play_word(9'd150, 9'd3, to);
        cmp_cnt++;
        if ({to, obs_q.size() == exp_q.size()} !== 2'b01) begin err_cnt++; $display("FAIL replot_npulses: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            cmp_cnt++;
            if (obs_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL replot_plot[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        bit to;
        int n;
        logic [8:0] x0;
        logic [8:0] y0;
        for (int it = 0; it < 6; it++) begin
            clear_buf();
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) wr_char(8'h20);
                else wr_char(8'($urandom));
            end
            x0 = 9'($urandom);
            y0 = 9'($urandom);
            m_len_min = 1; m_len_max = 6;
            cmp_cnt++;
            if (char_count !== 5'(n)) begin err_cnt++; $display("FAIL rand%0d_count: got %0d expected %0d", it, char_count, n); end
            model_plots(int'(x0), int'(y0));
            play_word(x0, y0, to);
            cmp_cnt++;
            if ({to, obs_q.size() == exp_q.size()} !== 2'b01) begin err_cnt++; $display("FAIL rand%0d_npulses: got %0d expected %0d", it, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                cmp_cnt++;
                if (obs_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL rand%0d_plot[%0d]: got %h expected %h", it, i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_space();
        bit to;
        logic [8:0] x0;
        x0 = 9'($urandom_range(0, 200));
        clear_buf();
        wr_char(8'h41); wr_char(8'h20); wr_char(8'h42);
        m_len_min = 2; m_len_max = 5;
        model_plots(int'(x0), 77);
        play_word(x0, 9'd77, to);
        cmp_cnt++;
        if ({to, obs_q.size() == SPACE_PULSES} !== 2'b01) begin err_cnt++; $display("FAIL space_npulses: got %0d expected %0d", obs_q.size(), SPACE_PULSES); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            cmp_cnt++;
            if (obs_q[i] !== exp_q[i]) begin err_cnt++; $display("FAIL space_plot[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        clear_buf();
        wr_char(8'h61); wr_char(8'h62); wr_char(8'h63);
        m_len_min = 6; m_len_max = 6;
        obs_q.delete();
        @(negedge clk);
        x_origin = 9'd50; y_origin = 9'd60; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (obs_q.size() >= 2) begin seen = 1'b1; break; end
        end
        cmp_cnt++;
        if (seen !== 1'b1) begin err_cnt++; $display("FAIL resetmid_reach: got %0d pulses expected 2", obs_q.size()); end
        repeat (3) @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        cmp_cnt++;
        if ({address, x_input, y_input, enable_character_plot, busy, done, char_count, overflow} !== 35'd0) begin
            err_cnt++; $display("FAIL resetmid_outputs: got %h expected 0",
                                {address, x_input, y_input, enable_character_plot, busy, done, char_count, overflow});
        end
        @(negedge clk);
        resetn = 1'b1;
        mdl_buf.delete();
        mdl_ovf = 1'b0;
        obs_q.delete();
        repeat (5) @(negedge clk);
        cmp_cnt++;
        if ({busy, char_count, obs_q.size() == 0} !== 7'b0000001) begin
            err_cnt++; $display("FAIL resetmid_after: got busy=%b count=%0d pulses=%0d expected 0/0/0", busy, char_count, obs_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_empty();
        test_latency();
        test_timeout();
        test_busy_ignore();
        test_random();
        test_space();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/vga_word_sequencer.md
Name: vga_word_sequencer

Overview:
- Upstream feeder for the per-character VGA drawing stage.
- Buffers a word of up to MAX_CHARS character-ROM addresses.
- On start, hands the characters one at a time to the drawing stage: character address plus pixel origin, then one plot pulse.
- Waits for the drawing stage's ready handshake before each next character; advances x per character and wraps to a new text line at the screen edge.

Parameters:
- MAX_CHARS, 16, word buffer depth; must be a power of two.
- CHAR_W, 6, horizontal pixel advance per character.
- LINE_H, 8, vertical pixel advance on line wrap.
- X_MAX, 320, exclusive right screen edge in pixels.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- char_wr  input  1  append char_data to buffer this cycle.
- char_data  input  8  character-ROM address to append.
- buf_clear  input  1  empty buffer, clear overflow.
- start  input  1  begin plotting the buffered word.
- x_origin  input  9  first character x, sampled on start.
- y_origin  input  9  first character y, sampled on start.
- ready_to_start_character  input  1  drawing stage idle/done (level).
- address  output  8  character address to drawing stage.
- x_input  output  9  character pixel x to drawing stage.
- y_input  output  9  character pixel y to drawing stage.
- enable_character_plot  output  1  one-cycle plot request.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse, word finished.
- char_count  output  $clog2(MAX_CHARS)+1  characters buffered.
- overflow  output  1  sticky; a write was dropped because the buffer was full.

Behaviour:
- Reset values: all outputs 0, buffer count 0, FSM in IDLE.
- Buffer writes:
  - Accepted only in IDLE. Writes while busy are ignored and do not set overflow.
  - char_wr with char_count==MAX_CHARS drops the data and sets overflow.
  - buf_clear in IDLE sets count to 0 and clears overflow. It takes priority over a char_wr in the same cycle. buf_clear while busy is ignored.
  - Buffer contents are retained after done, so the same word can be replotted.
- FSM: IDLE -> LOAD -> ISSUE -> WAIT_ACK -> WAIT_DONE -> NEXT -> (ISSUE | FINISH) -> IDLE.
  - IDLE: start=1 goes to LOAD. start is ignored in any other state.
  - LOAD (1 cycle): latch x_origin and y_origin into x_cur and y_cur, set idx=0. If count==0, go to FINISH.
  - ISSUE (1 cycle): drive address=buf[idx], x_input=x_cur, y_input=y_cur, and assert enable_character_plot=1 for this cycle only. address, x_input and y_input are registered and held stable until the next ISSUE.
  - WAIT_ACK: wait for ready_to_start_character==0, meaning the drawing stage accepted the request. If it is still 1 after 4 cycles, treat the request as accepted and proceed, so a stage that finishes instantly cannot deadlock the sequencer.
  - WAIT_DONE: wait for ready_to_start_character==1.
  - NEXT (1 cycle): idx++.
    - If idx==count, go to FINISH.
    - Otherwise set x_cur += CHAR_W.
    - If (x_cur + CHAR_W) + CHAR_W > X_MAX, also set x_cur = x_origin_latched and y_cur += LINE_H (9-bit, wraps modulo 512).
    - Then go to ISSUE.
  - FINISH (1 cycle): done=1, then IDLE.
- busy=1 in every state except IDLE.
- Latency: start in cycle 0 gives enable_character_plot in cycle 2. Empty buffer: done in cycle 2.
- Reset mid-sequence returns to IDLE immediately with the buffer emptied. The downstream stage is reset by the same resetn.
- Arithmetic: x computations use 10-bit intermediates; the output is truncated to 9 bits.

Optional Feature:
- Macro: SPACE_SKIP_EN.
- Defined: a buffered address equal to 8'h20 (space) is not issued. NEXT is entered directly from the skip check with no enable pulse and no handshake, and x still advances by CHAR_W. A trailing space still ends with done.
- Undefined: spaces are issued like any other character.

Test Plan:
- Write 3 chars 0x41,0x42,0x43; start with origin (10,20); drawing model drops ready 1 cycle after each pulse and raises it 5 cycles later -> 3 pulses with (addr,x,y) = (0x41,10,20), (0x42,16,20), (0x43,22,20); then done pulse; busy low.
- Origin x=306, 3 chars -> plots at (306,y), (312,y), then (306,y+8) after the wrap.
- Write 17 chars with MAX_CHARS=16 -> char_count=16, overflow=1; buf_clear -> char_count=0, overflow=0.
- start with empty buffer -> no enable_character_plot; done asserted in cycle 2; busy high for cycles 1-2.
- Hold ready high constantly -> each character proceeds after the 4-cycle ack timeout; no hang.
- Assert resetn=0 during WAIT_DONE of char 2 -> all outputs 0 and char_count=0 immediately. SPACE_SKIP_EN build with word 0x41,0x20,0x42 -> 2 pulses, at x0 and x0+12.
